rob_recovery_ctrl: RTL and testbench
====================================

Name: rob_recovery_ctrl

Overview:
- Sequences branch-mispredict recovery around the ROB.
- Accepts one rollback request, issues a single-cycle rollback strobe to the ROB, then walks the squashed ROB entries from youngest to oldest.
- For each squashed entry it returns T to the free list and restores map_table[dest] to T_old.
- Holds dispatch stalled from request acceptance until the walk completes. Sits between the branch-resolution logic, the ROB, the free list and the map table.

Parameters:
NUM_ROB, 32, ROB entries (power of 2); RW = $clog2(NUM_ROB)
NUM_PR, 64, physical registers; PW = $clog2(NUM_PR)
NUM_ARCH_TABLE, 32, architectural registers; AW = $clog2(NUM_ARCH_TABLE)
ZERO_REG, 31, architectural index never renamed; its entries are skipped

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset
en  in  1  global enable; 0 freezes all state, strobes forced 0
rollback_req  in  1  mispredict request from branch resolution
rollback_idx  in  RW  ROB index of mispredicted branch
rob_tail  in  RW  ROB next-write index (sampled on accept)
walk_T  in  PW  ROB read data: T of entry at walk_idx (combinational read)
walk_T_old  in  PW  ROB read data: T_old of entry at walk_idx
walk_dest  in  AW  ROB read data: dest_idx of entry at walk_idx
free_ready  in  1  free list can accept a returned register this cycle
rollback_en  out  1  one-cycle strobe to ROB
rollback_idx_out  out  RW  captured branch index, valid with rollback_en
walk_idx  out  RW  ROB read address
free_en  out  1  return free_T to free list
free_T  out  PW  register returned
map_restore_en  out  1  write map_table[map_restore_dest] = map_restore_T
map_restore_dest  out  AW  arch index to restore
map_restore_T  out  PW  restored physical register (T_old)
stall_dispatch  out  1  block dispatch
busy  out  1  FSM not IDLE
done  out  1  one-cycle pulse at end of recovery

Behaviour:
- Reset (async, reset=0):
  - State IDLE.
  - All outputs 0.
  - Internal branch register B, walk_ptr and count are 0.
  - A reset during any state aborts recovery immediately, with no further strobes.
- IDLE:
  - stall_dispatch=0, busy=0.
  - On en && rollback_req:
    - capture B=rollback_idx;
    - walk_ptr = rob_tail-1 (mod NUM_ROB);
    - count = (rob_tail-B-1) mod NUM_ROB, computed in RW-bit wrap arithmetic;
    - go to FLUSH.
  - The accept cycle itself asserts no outputs.
- FLUSH (one cycle):
  - rollback_en=1, rollback_idx_out=B, stall_dispatch=1, busy=1.
  - Next state is DONE if count==0, else WALK.
- WALK:
  - stall_dispatch=1, busy=1, walk_idx=walk_ptr.
  - Each cycle with free_ready=1 the entry at walk_ptr is processed:
    - if walk_dest != ZERO_REG: free_en=1 with free_T=walk_T, and map_restore_en=1 with map_restore_dest=walk_dest and map_restore_T=walk_T_old;
    - if walk_dest == ZERO_REG: both strobes stay 0 but the entry is still consumed;
    - walk_ptr decrements with wrap (0 -> NUM_ROB-1) and count decrements.
  - When count reaches 0, go to DONE.
  - With free_ready=0: no strobes, walk_ptr and count hold.
  - Youngest-to-oldest order is mandatory: after multiple writes to the same dest, the map table ends holding the oldest squashed T_old.
- DONE (one cycle):
  - done=1, stall_dispatch=1, busy=1.
  - Next state IDLE. stall_dispatch drops in the following cycle.
- Latency: accepted at cycle N, with free_ready held high:
  - rollback_en at N+1;
  - strobes at N+2 .. N+1+count;
  - done at N+2+count.
- Request while busy: rollback_req is ignored in FLUSH, WALK and DONE. Upstream guarantees at most one outstanding mispredict.
- Full ROB (tail==head): the count formula holds unchanged.
- en=0: state, B, walk_ptr and count hold; rollback_en, free_en, map_restore_en and done are forced 0; stall_dispatch and busy keep their state-derived value.
- walk_idx outside WALK equals walk_ptr; don't-care for consumers.

Test Plan:
- Basic: B=3, rob_tail=7, free_ready=1 -> rollback_en at N+1 with idx 3; free_en at N+2..N+4 with walk_idx 6,5,4; done at N+5; stall_dispatch high N+1..N+5.
- Wrap: B=30, rob_tail=2 -> count 3; walk_idx 1,0,31; done at N+5.
- Empty squash: B=9, rob_tail=10 -> rollback_en at N+1, no free_en or map_restore_en, done at N+2.
- Backpressure: B=3, rob_tail=7, free_ready low for 2 cycles after the first strobe -> walk_idx holds at 5, no strobes while low, done at N+7.
- Zero reg and same-dest: entries 6,5,4 have dest 31,4,4 with T_old 20,21 at 5,4 -> no strobes for entry 6; map restores for dest 4 issued in order T_old 20 then 21. A second rollback_req during WALK is ignored.
- Reset mid-walk: reset=0 asynchronously at the second strobe -> all outputs 0 immediately, IDLE. After release, a new request at B=0, rob_tail=2 completes normally.

Source files
------------

// File: rtl/rob_recovery_ctrl_if.sv
// ----------------------------------------------------------------------------
// rob_recovery_ctrl_if
// Bundles every signal between the mispredict-recovery sequencer and its
// neighbours (branch resolution, ROB, free list, map table).
//
// Port summary (as seen from the recovery controller, modport master):
//   in : en, rollback_req, rollback_idx, rob_tail,
//        walk_T, walk_T_old, walk_dest, free_ready
//   out: rollback_en, rollback_idx_out, walk_idx,
//        free_en, free_T,
//        map_restore_en, map_restore_dest, map_restore_T,
//        stall_dispatch, busy, done
// The slave modport is the mirror image used by the surrounding logic.
// ----------------------------------------------------------------------------
interface rob_recovery_ctrl_if #(
    parameter int NUM_ROB        = 32,
    parameter int NUM_PR         = 64,
    parameter int NUM_ARCH_TABLE = 32
);
    localparam int RW = $clog2(NUM_ROB);
    localparam int PW = $clog2(NUM_PR);
    localparam int AW = $clog2(NUM_ARCH_TABLE);

    logic          en;
    logic          rollback_req;
    logic [RW-1:0] rollback_idx;
    logic [RW-1:0] rob_tail;
    logic [PW-1:0] walk_T;
    logic [PW-1:0] walk_T_old;
    logic [AW-1:0] walk_dest;
    logic          free_ready;

    logic          rollback_en;
    logic [RW-1:0] rollback_idx_out;
    logic [RW-1:0] walk_idx;
    logic          free_en;
    logic [PW-1:0] free_T;
    logic          map_restore_en;
    logic [AW-1:0] map_restore_dest;
    logic [PW-1:0] map_restore_T;
    logic          stall_dispatch;
    logic          busy;
    logic          done;

    modport master (
        input  en, rollback_req, rollback_idx, rob_tail,
               walk_T, walk_T_old, walk_dest, free_ready,
        output rollback_en, rollback_idx_out, walk_idx,
               free_en, free_T,
               map_restore_en, map_restore_dest, map_restore_T,
               stall_dispatch, busy, done
    );

    modport slave (
        output en, rollback_req, rollback_idx, rob_tail,
               walk_T, walk_T_old, walk_dest, free_ready,
        input  rollback_en, rollback_idx_out, walk_idx,
               free_en, free_T,
               map_restore_en, map_restore_dest, map_restore_T,
               stall_dispatch, busy, done
    );
endinterface

// File: rtl/rob_recovery_ctrl.sv
// ----------------------------------------------------------------------------
// rob_recovery_ctrl
// Sequences branch-mispredict recovery: accepts one rollback request, pulses
// rollback_en to the ROB for a single cycle, then walks the squashed ROB
// entries youngest to oldest, returning each T to the free list and restoring
// map_table[dest] to T_old. Dispatch is stalled from the cycle after accept
// until the done pulse.
//
// Ports:
//   clock - rising-edge system clock
//   reset - asynchronous, active-low reset
//   bus   - rob_recovery_ctrl_if.master (request, ROB read port, free-list
//           return, map-table restore, status outputs)
// ----------------------------------------------------------------------------
module rob_recovery_ctrl #(
    parameter int NUM_ROB        = 32,
    parameter int NUM_PR         = 64,
    parameter int NUM_ARCH_TABLE = 32,
    parameter int ZERO_REG       = 31
) (
    input  logic                       clock,
    input  logic                       reset,
    rob_recovery_ctrl_if.master        bus
);
    localparam int RW = $clog2(NUM_ROB);
    localparam int PW = $clog2(NUM_PR);
    localparam int AW = $clog2(NUM_ARCH_TABLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        WALK  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] branchIdx_q, branchIdx_d;
    logic [RW-1:0] walkPtr_q, walkPtr_d;
    logic [RW-1:0] count_q, count_d;

    // An entry is consumed only when enabled, walking, and the free list
    // can take the returned register this cycle.
    logic consume;
    assign consume = bus.en && (state_q == WALK) && bus.free_ready;

    // State and walk bookkeeping registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            branchIdx_q <= '0;
            walkPtr_q   <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            branchIdx_q <= branchIdx_d;
            walkPtr_q   <= walkPtr_d;
            count_q     <= count_d;
        end
    end

    // Next-state logic. Everything holds while en is low. The squash count
    // uses RW-bit wrap arithmetic, so a full ROB needs no special case.
    always_comb begin
        state_d     = state_q;
        branchIdx_d = branchIdx_q;
        walkPtr_d   = walkPtr_q;
        count_d     = count_q;
        if (bus.en) begin
            case (state_q)
                IDLE: begin
                    if (bus.rollback_req) begin
                        branchIdx_d = bus.rollback_idx;
                        walkPtr_d   = RW'(bus.rob_tail - RW'(1));
                        count_d     = RW'(bus.rob_tail - bus.rollback_idx - RW'(1));
                        state_d     = FLUSH;
                    end
                end
                FLUSH: begin
                    state_d = (count_q == '0) ? DONE : WALK;
                end
                WALK: begin
                    if (bus.free_ready) begin
                        walkPtr_d = RW'(walkPtr_q - RW'(1));
                        count_d   = RW'(count_q - RW'(1));
                        if (count_q == RW'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output logic. Data outputs are gated with their strobes so that they
    // read as zero whenever nothing is being returned or restored.
    always_comb begin
        bus.rollback_en      = bus.en && (state_q == FLUSH);
        bus.rollback_idx_out = branchIdx_q;
        bus.walk_idx         = walkPtr_q;
        bus.stall_dispatch   = (state_q != IDLE);
        bus.busy             = (state_q != IDLE);
        bus.done             = bus.en && (state_q == DONE);
        bus.free_en          = 1'b0;
        bus.free_T           = PW'(0);
        bus.map_restore_en   = 1'b0;
        bus.map_restore_dest = AW'(0);
        bus.map_restore_T    = PW'(0);
        if (consume && (bus.walk_dest != AW'(ZERO_REG))) begin
            bus.free_en          = 1'b1;
            bus.free_T           = bus.walk_T;
            bus.map_restore_en   = 1'b1;
            bus.map_restore_dest = bus.walk_dest;
            bus.map_restore_T    = bus.walk_T_old;
        end
    end
endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rob_recovery_ctrl
// Self-checking bench for rob_recovery_ctrl. A small ROB model answers the
// walk reads; every request pushes the strobes it should cause onto a
// scoreboard queue, and a negedge monitor pops and compares them. Each test
// task also checks latency, walk order and stall behaviour inline.
// ----------------------------------------------------------------------------
module tb_rob_recovery_ctrl;
    localparam int NUM_ROB  = 32;
    localparam int RW       = 5;
    localparam int PW       = 6;
    localparam int AW       = 5;
    localparam int ZERO_REG = 31;

    typedef struct packed {
        logic [RW-1:0] idx;
        logic [PW-1:0] t;
        logic [AW-1:0] dest;
        logic [PW-1:0] told;
    } exp_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    rob_recovery_ctrl_if bus ();

    rob_recovery_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [PW-1:0] robT    [NUM_ROB];
    logic [PW-1:0] robTold [NUM_ROB];
    logic [AW-1:0] robDest [NUM_ROB];
    logic [PW-1:0] mapSeen [NUM_ROB];
    logic [RW-1:0] walkLog [32];
    exp_t          sbq[$];
    exp_t          popped;
    logic [32:0]   allOut;

    // Combinational ROB read port answering the walk address.
    always_comb begin
        bus.walk_T     = robT[bus.walk_idx];
        bus.walk_T_old = robTold[bus.walk_idx];
        bus.walk_dest  = robDest[bus.walk_idx];
    end

    // Map table as written by the DUT's restore port.
    always @(posedge clock) begin
        if (bus.map_restore_en) mapSeen[bus.map_restore_dest] <= bus.map_restore_T;
    end

    assign allOut = {bus.rollback_en, bus.rollback_idx_out, bus.walk_idx, bus.free_en,
                     bus.free_T, bus.map_restore_en, bus.map_restore_dest,
                     bus.map_restore_T, bus.stall_dispatch, bus.busy, bus.done};

    // Scoreboard monitor: every strobe must match the next expected entry.
    always @(negedge clock) begin
        if (reset && (bus.free_en || bus.map_restore_en)) begin
            checks++;
            if (bus.free_en !== bus.map_restore_en) begin
                errors++;
                $display("[TB] FAIL strobe_pair: free_en=%0b map_restore_en=%0b, required equal",
                         bus.free_en, bus.map_restore_en);
            end else if (sbq.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_strobe: walk_idx=%0d free_T=%0d, required no strobe",
                         bus.walk_idx, bus.free_T);
            end else begin
                popped = sbq.pop_front();
                if ({bus.walk_idx, bus.free_T, bus.map_restore_dest, bus.map_restore_T} !== popped) begin
                    errors++;
                    $display("[TB] FAIL strobe_data: idx/T/dest/Told got %0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
                             bus.walk_idx, bus.free_T, bus.map_restore_dest, bus.map_restore_T,
                             popped.idx, popped.t, popped.dest, popped.told);
                end
            end
        end
    end

    task automatic initRob();
        for (int i = 0; i < NUM_ROB; i++) begin
            robT[i]    = PW'(32 + i);
            robTold[i] = PW'(i);
            robDest[i] = AW'(i % 16);
            mapSeen[i] = '0;
        end
    endtask

    // Pushes the expected strobes of a rollback from the ROB model contents.
    task automatic applyStimulus(input logic [RW-1:0] b, input logic [RW-1:0] tail);
        logic [RW-1:0] p;
        logic [RW-1:0] c;
        exp_t          e;
        p = tail - 5'd1;
        c = tail - b - 5'd1;
        while (c != 0) begin
            if (robDest[p] != AW'(ZERO_REG)) begin
                e.idx  = p;
                e.t    = robT[p];
                e.dest = robDest[p];
                e.told = robTold[p];
                sbq.push_back(e);
            end
            p = p - 5'd1;
            c = c - 5'd1;
        end
        bus.rollback_idx = b;
        bus.rob_tail     = tail;
        bus.rollback_req = 1'b1;
    endtask

    // Runs one recovery after applyStimulus and records what happened,
    // bounded by maxCyc cycles. Cycle k counts from the accept cycle N.
    task automatic checkOutput(input int maxCyc, input int lowStart, input int lowLen,
                               input bit gateEn, input int reqAt,
                               output int rbAt, output int doneAt, output int nStrobes,
                               output bit stallOk, output bit stallAfter,
                               output logic [RW-1:0] rbIdx);
        bit lowNow;
        rbAt = -1; doneAt = -1; nStrobes = 0; stallOk = 1'b1; stallAfter = 1'b1; rbIdx = '0;
        @(posedge clock); #1;
        bus.rollback_req = 1'b0;
        for (int k = 1; k <= maxCyc; k++) begin
            lowNow = (k >= lowStart) && (k < lowStart + lowLen);
            if (gateEn) bus.en = !lowNow;
            else        bus.free_ready = !lowNow;
            if (k == reqAt) begin
                bus.rollback_req = 1'b1;
                bus.rollback_idx = 5'd17;
                bus.rob_tail     = 5'd20;
            end else begin
                bus.rollback_req = 1'b0;
            end
            #1;
            walkLog[k] = bus.walk_idx;
            if (bus.rollback_en) begin rbAt = k; rbIdx = bus.rollback_idx_out; end
            if (bus.free_en) nStrobes++;
            if (!bus.stall_dispatch || !bus.busy) stallOk = 1'b0;
            if (bus.done) doneAt = k;
            @(posedge clock); #1;
            if (doneAt >= 0) break;
        end
        bus.en = 1'b1; bus.free_ready = 1'b1; bus.rollback_req = 1'b0;
        #1;
        stallAfter = bus.stall_dispatch | bus.busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (allOut !== 33'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h, required 0", allOut);
        end
        #3 reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if ({bus.stall_dispatch, bus.busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: stall/busy=%b, required 00",
                     {bus.stall_dispatch, bus.busy});
        end
    endtask

    task automatic test_basic();
        int rbAt, doneAt, n; bit sOk, sAft; logic [RW-1:0] rbIdx;
        applyStimulus(5'd3, 5'd7);
        checkOutput(20, 99, 0, 1'b0, 0, rbAt, doneAt, n, sOk, sAft, rbIdx);
        checks++;
        if (rbAt != 1 || rbIdx !== 5'd3) begin
            errors++;
            $display("[TB] FAIL basic_rollback: cycle %0d idx %0d, required cycle 1 idx 3", rbAt, rbIdx);
        end
        checks++;
        if (doneAt != 5 || n != 3) begin
            errors++;
            $display("[TB] FAIL basic_done: done %0d strobes %0d, required done 5 strobes 3", doneAt, n);
        end
        checks++;
        if ({walkLog[2], walkLog[3], walkLog[4]} !== {5'd6, 5'd5, 5'd4}) begin
            errors++;
            $display("[TB] FAIL basic_walk_order: got %0d,%0d,%0d, required 6,5,4",
                     walkLog[2], walkLog[3], walkLog[4]);
        end
        checks++;
        if (!sOk || sAft) begin
            errors++;
            $display("[TB] FAIL basic_stall: held=%0b after=%0b, required held=1 after=0", sOk, sAft);
        end
    endtask

    task automatic test_wrap();
        int rbAt, doneAt, n; bit sOk, sAft; logic [RW-1:0] rbIdx;
        applyStimulus(5'd30, 5'd2);
        checkOutput(20, 99, 0, 1'b0, 0, rbAt, doneAt, n, sOk, sAft, rbIdx);
        checks++;
        if (doneAt != 5 || n != 3 || rbIdx !== 5'd30) begin
            errors++;
            $display("[TB] FAIL wrap_done: done %0d strobes %0d idx %0d, required 5 3 30", doneAt, n, rbIdx);
        end
        checks++;
        if ({walkLog[2], walkLog[3], walkLog[4]} !== {5'd1, 5'd0, 5'd31}) begin
            errors++;
            $display("[TB] FAIL wrap_walk_order: got %0d,%0d,%0d, required 1,0,31",
                     walkLog[2], walkLog[3], walkLog[4]);
        end
    endtask

    task automatic test_empty();
        int rbAt, doneAt, n; bit sOk, sAft; logic [RW-1:0] rbIdx;
        applyStimulus(5'd9, 5'd10);
        checkOutput(20, 99, 0, 1'b0, 0, rbAt, doneAt, n, sOk, sAft, rbIdx);
        checks++;
        if (rbAt != 1 || doneAt != 2 || n != 0 || rbIdx !== 5'd9) begin
            errors++;
            $display("[TB] FAIL empty_squash: rb %0d done %0d strobes %0d, required rb 1 done 2 strobes 0",
                     rbAt, doneAt, n);
        end
    endtask

    task automatic test_backpressure();
        int rbAt, doneAt, n; bit sOk, sAft; logic [RW-1:0] rbIdx;
        applyStimulus(5'd3, 5'd7);
        checkOutput(20, 3, 2, 1'b0, 0, rbAt, doneAt, n, sOk, sAft, rbIdx);
        checks++;
        if (doneAt != 7 || n != 3) begin
            errors++;
            $display("[TB] FAIL backpressure_done: done %0d strobes %0d, required done 7 strobes 3", doneAt, n);
        end
        checks++;
        if (walkLog[3] !== 5'd5 || walkLog[4] !== 5'd5) begin
            errors++;
            $display("[TB] FAIL backpressure_hold: walk_idx %0d,%0d, required 5,5", walkLog[3], walkLog[4]);
        end
    endtask

    task automatic test_enable();
        int rbAt, doneAt, n; bit sOk, sAft; logic [RW-1:0] rbIdx;
        applyStimulus(5'd3, 5'd7);
        checkOutput(20, 3, 2, 1'b1, 0, rbAt, doneAt, n, sOk, sAft, rbIdx);
        checks++;
        if (doneAt != 7 || n != 3 || !sOk) begin
            errors++;
            $display("[TB] FAIL enable_freeze: done %0d strobes %0d busy_held %0b, required 7 3 1",
                     doneAt, n, sOk);
        end
    endtask

    task automatic test_zero_same_dest();
        int rbAt, doneAt, n; bit sOk, sAft; logic [RW-1:0] rbIdx;
        robDest[6] = AW'(ZERO_REG);
        robDest[5] = 5'd4;
        robDest[4] = 5'd4;
        robTold[5] = 6'd20;
        robTold[4] = 6'd21;
        mapSeen[4] = '0;
        applyStimulus(5'd3, 5'd7);
        checkOutput(20, 99, 0, 1'b0, 3, rbAt, doneAt, n, sOk, sAft, rbIdx);
        checks++;
        if (doneAt != 5 || n != 2) begin
            errors++;
            $display("[TB] FAIL zero_reg_walk: done %0d strobes %0d, required done 5 strobes 2", doneAt, n);
        end
        checks++;
        if (mapSeen[4] !== 6'd21) begin
            errors++;
            $display("[TB] FAIL same_dest_final: map[4]=%0d, required 21", mapSeen[4]);
        end
        checks++;
        if (sAft) begin
            errors++;
            $display("[TB] FAIL busy_request_ignored: busy after done=%0b, required 0", sAft);
        end
        initRob();
    endtask

    task automatic test_reset_mid_walk();
        int rbAt, doneAt, n; bit sOk, sAft; logic [RW-1:0] rbIdx;
        applyStimulus(5'd3, 5'd7);
        @(posedge clock); #1;
        bus.rollback_req = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        checks++;
        if (bus.free_en !== 1'b1 || bus.walk_idx !== 5'd5) begin
            errors++;
            $display("[TB] FAIL second_strobe_present: free_en=%0b idx=%0d, required 1 5",
                     bus.free_en, bus.walk_idx);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (allOut !== 33'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_walk: outputs %h, required 0", allOut);
        end
        sbq.delete();
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock); #1;
        applyStimulus(5'd0, 5'd2);
        checkOutput(20, 99, 0, 1'b0, 0, rbAt, doneAt, n, sOk, sAft, rbIdx);
        checks++;
        if (rbAt != 1 || doneAt != 3 || n != 1 || walkLog[2] !== 5'd1) begin
            errors++;
            $display("[TB] FAIL after_reset_request: rb %0d done %0d strobes %0d idx %0d, required 1 3 1 1",
                     rbAt, doneAt, n, walkLog[2]);
        end
    endtask

    task automatic checkDrained(input string name);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drained: %0d strobes outstanding, required 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.en           = 1'b1;
        bus.free_ready   = 1'b1;
        bus.rollback_req = 1'b0;
        bus.rollback_idx = '0;
        bus.rob_tail     = '0;
        initRob();
        test_reset();
        test_basic();          checkDrained("basic");
        test_wrap();           checkDrained("wrap");
        test_empty();          checkDrained("empty");
        test_backpressure();   checkDrained("backpressure");
        test_enable();         checkDrained("enable");
        test_zero_same_dest(); checkDrained("zero_same_dest");
        test_reset_mid_walk(); checkDrained("reset_mid_walk");
        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
